vga_driver: RTL and testbench

//  VGA 640x480@60Hz timing generator. Runs on the 25 MHz pixel clock.

---
 rtl/vga_driver.sv | 97 +++++++++
 tb/tb_vga_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_driver.sv
// 640x480@60Hz VGA timing generator on the 25 MHz pixel clock.
// Sync/enable/request outputs are registered decodes of the next counter state, so they track the counters with no lag.
module vga_driver #(
  parameter logic [9:0] H_SYNC  = 10'd96,
  parameter logic [9:0] H_BACK  = 10'd48,
  parameter logic [9:0] H_DISP  = 10'd640,
  parameter logic [9:0] H_FRONT = 10'd16,
  parameter logic [9:0] V_SYNC  = 10'd2,
  parameter logic [9:0] V_BACK  = 10'd33,
  parameter logic [9:0] V_DISP  = 10'd480,
  parameter logic [9:0] V_FRONT = 10'd10
) (
  input  logic        vga_clk_25,
  input  logic        rst_n,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [15:0] vga_rgb,
  output logic        frame_end
);

  localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_DISP;
  localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
  localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_DISP;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       en_q, en_d;
  logic       fe_q, fe_d;
  logic [9:0] xpos_q, xpos_d;
  logic [9:0] ypos_q, ypos_d;
  logic       h_wrap;
  logic       v_line;
  logic       req;

  always_comb begin
    h_wrap  = (h_cnt_q == H_TOTAL - 10'd1);
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_TOTAL - 10'd1) ? 10'd0 : v_cnt_q + 10'd1;
    end

    // Outputs are decoded from the counter values they will sit beside next cycle.
    hs_d   = (h_cnt_d >= H_SYNC);
    vs_d   = (v_cnt_d >= V_SYNC);
    v_line = (v_cnt_d >= V_ACT_START) && (v_cnt_d < V_ACT_END);
    en_d   = v_line && (h_cnt_d >= H_ACT_START) && (h_cnt_d < H_ACT_END);
    req    = v_line && (h_cnt_d >= H_REQ_START) && (h_cnt_d < H_REQ_END);
    xpos_d = req ? h_cnt_d - H_REQ_START : 10'd0;
    ypos_d = req ? v_cnt_d - V_ACT_START : 10'd0;
    fe_d   = (h_cnt_d == H_TOTAL - 10'd1) && (v_cnt_d == V_TOTAL - 10'd1);
  end

  // A reset edge parks everything at the (0,0) decode, which is all-zero.
  always_ff @(posedge vga_clk_25) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      en_q    <= 1'b0;
      fe_q    <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      en_q    <= en_d;
      fe_q    <= fe_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
    end
  end

  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_en     = en_q;
  assign frame_end  = fe_q;
  assign pixel_xpos = xpos_q;
  assign pixel_ypos = ypos_q;
  // Renderer answers one clock after the request, exactly when vga_en covers that pixel.
  assign vga_rgb    = en_q ? pixel_data : 16'h0000;

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver: a full-size instance (first lines plus a mid-frame reset) and a
// shrunken-timing instance (many whole frames with random resets), both against an arithmetic model.
module tb_vga_driver;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] render(input logic [9:0] x, input logic [9:0] y, input logic [15:0] salt);
    return {y[5:0], x} ^ salt;
  endfunction

  // t = clocks since the last reset edge; position on screen follows by division.
  function automatic logic [39:0] expect_out(input int t, input int hs, input int hb, input int hd, input int hf,
                                             input int vs, input int vb, input int vd, input int vf,
                                             input logic [15:0] salt);
    int ht, vt, h, v, x, y;
    logic hsy, vsy, vline, en, req, fe;
    logic [15:0] rgb;
    ht    = hs + hb + hd + hf;
    vt    = vs + vb + vd + vf;
    h     = t % ht;
    v     = (t / ht) % vt;
    hsy   = (h >= hs);
    vsy   = (v >= vs);
    vline = (v >= vs + vb) && (v < vs + vb + vd);
    en    = vline && (h >= hs + hb) && (h < hs + hb + hd);
    req   = vline && (h >= hs + hb - 1) && (h < hs + hb + hd - 1);
    x     = req ? h - (hs + hb - 1) : 0;
    y     = req ? v - (vs + vb) : 0;
    fe    = (h == ht - 1) && (v == vt - 1);
    rgb   = en ? render(10'(h - (hs + hb)), 10'(v - (vs + vb)), salt) : 16'h0000;
    return {hsy, vsy, en, fe, 10'(x), 10'(y), rgb};
  endfunction

  logic [15:0] salt;

  logic        rst_dflt, rst_small;
  logic [15:0] pd_dflt, pd_small;
  logic [9:0]  x_dflt, y_dflt, x_small, y_small;
  logic        hs_dflt, vs_dflt, en_dflt, fe_dflt;
  logic        hs_small, vs_small, en_small, fe_small;
  logic [15:0] rgb_dflt, rgb_small;

  vga_driver dut_dflt (
    .vga_clk_25(clk), .rst_n(rst_dflt), .pixel_data(pd_dflt),
    .pixel_xpos(x_dflt), .pixel_ypos(y_dflt), .vga_hs(hs_dflt), .vga_vs(vs_dflt),
    .vga_en(en_dflt), .vga_rgb(rgb_dflt), .frame_end(fe_dflt)
  );

  vga_driver #(
    .H_SYNC(10'd4), .H_BACK(10'd3), .H_DISP(10'd10), .H_FRONT(10'd2),
    .V_SYNC(10'd2), .V_BACK(10'd2), .V_DISP(10'd5),  .V_FRONT(10'd1)
  ) dut_small (
    .vga_clk_25(clk), .rst_n(rst_small), .pixel_data(pd_small),
    .pixel_xpos(x_small), .pixel_ypos(y_small), .vga_hs(hs_small), .vga_vs(vs_small),
    .vga_en(en_small), .vga_rgb(rgb_small), .frame_end(fe_small)
  );

  int   t_dflt = 0, t_small = 0;
  logic seen_rst_dflt = 1'b0, seen_rst_small = 1'b0;
  logic started = 1'b0;
  logic phase_b = 1'b0;

  // Model timebase and the registered renderer for both instances.
  always @(posedge clk) begin
    t_dflt         <= rst_dflt ? t_dflt + 1 : 0;
    t_small        <= rst_small ? t_small + 1 : 0;
    seen_rst_dflt  <= rst_dflt;
    seen_rst_small <= rst_small;
    started        <= 1'b1;
    pd_dflt        <= render(x_dflt, y_dflt, salt);
    pd_small       <= render(x_small, y_small, salt);
  end

  int   hs_low = 0, line_len = 0, vs_low = 0;
  logic hs_prev = 1'b0, vs_prev = 1'b0, line_valid = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      check($sformatf("dflt t=%0d", t_dflt),
            {hs_dflt, vs_dflt, en_dflt, fe_dflt, x_dflt, y_dflt, rgb_dflt},
            expect_out(t_dflt, 96, 48, 640, 16, 2, 33, 480, 10, salt));
      if (!seen_rst_dflt) begin
        hs_low = 1; vs_low = 1; line_len = 0; line_valid = 1'b0;
        hs_prev = 1'b0; vs_prev = 1'b0;
      end else begin
        line_len++;
        if (!hs_dflt) hs_low++;
        if (!vs_dflt) vs_low++;
        if (hs_dflt && !hs_prev) begin
          check("hs_low_clocks", 64'(hs_low), 64'd96);
          if (line_valid) check("line_period", 64'(line_len), 64'd800);
          hs_low = 0; line_len = 0; line_valid = 1'b1;
        end
        if (vs_dflt && !vs_prev) begin
          check("vs_low_clocks", 64'(vs_low), 64'd1600);
          vs_low = 0;
        end
        hs_prev = hs_dflt;
        vs_prev = vs_dflt;
      end
    end
  end

  int   s_en = 0, s_rgb = 0, s_lines = 0, s_period = 0;
  logic s_en_prev = 1'b0, s_seen_fe = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      check($sformatf("small t=%0d", t_small),
            {hs_small, vs_small, en_small, fe_small, x_small, y_small, rgb_small},
            expect_out(t_small, 4, 3, 10, 2, 2, 2, 5, 1, salt));
      if (phase_b) begin
        s_period++;
        if (en_small) s_en++;
        if (rgb_small != 16'h0000) s_rgb++;
        if (en_small && !s_en_prev) s_lines++;
        s_en_prev = en_small;
        if (fe_small) begin
          if (s_seen_fe) begin
            check("frame_period", 64'(s_period), 64'd190);
            check("en_per_frame", 64'(s_en), 64'd50);
            check("rgb_per_frame", 64'(s_rgb), 64'd50);
            check("lines_per_frame", 64'(s_lines), 64'd5);
          end
          s_seen_fe = 1'b1;
          s_period = 0; s_en = 0; s_rgb = 0; s_lines = 0;
        end
      end
    end
  end

  initial begin
    rst_small = 1'b0;
    repeat (2) @(negedge clk);
    rst_small = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) begin
        rst_small = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      rst_small = 1'b1;
    end
    phase_b = 1'b1;
  end

  initial begin
    logic found;
    rst_dflt = 1'b0;
    salt     = 16'($urandom) | 16'h8000;
    repeat (3) @(negedge clk);
    rst_dflt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (t_dflt == 36 * 800 + 400) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_midframe", 64'(found), 64'd1);
    rst_dflt = 1'b0;
    repeat (3) @(negedge clk);
    rst_dflt = 1'b1;
    repeat (2000) @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
